// File: rtl/pipe_stage_reg_pkg.sv
// Shared types, occupancy constants and the saturating-add helper for the
// pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // Counters up to 32 bits wide; callers pass their own all-ones limit.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                          input logic [1:0]  inc,
                                          input logic [31:0] lim = 32'hFFFF_FFFF);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {31'b0, inc};
    if (sum > {1'b0, lim}) begin
      return lim;
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream and downstream valid/ready/data signals of one pipeline stage.
// The stage itself uses the slave modport; the surrounding logic uses master.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One valid+data holding register. Clear wins over load; an invalid slot can
// optionally be forced to zero so stale payloads never leak downstream.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ZERO_INVALID = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      if (ZERO_INVALID != 0) begin
        data <= '0;
      end
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid slot so
// in_ready is registered, and saturating stall/flush-drop counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int SKID         = 1,
  parameter int ZERO_INVALID = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONES = '1;

  pipe_state_t       state_q;
  pipe_state_t       state_d;
  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_clear;
  logic              skid_load;
  logic              skid_clear;
  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] main_d;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [1:0]        stall_inc;
  logic [1:0]        drop_inc;

  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = main_valid && bus.out_ready;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;

  // When the skid slot is occupied it is always older than the input beat.
  assign main_d = (state_q == FULL) ? skid_data : bus.in_data;

  pipe_slot #(
    .DATA_W       (DATA_W),
    .ZERO_INVALID (ZERO_INVALID)
  ) u_main (
    .clk   (clk),
    .rst   (resetn),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_valid),
    .data  (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(
        .DATA_W       (DATA_W),
        .ZERO_INVALID (ZERO_INVALID)
      ) u_skid (
        .clk   (clk),
        .rst   (resetn),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (bus.in_data),
        .valid (skid_valid),
        .data  (skid_data)
      );
      assign bus.in_ready = !resetn && (state_q != FULL);
    end else begin : g_noskid
      logic unused_skid_ctl;
      assign unused_skid_ctl = skid_load | skid_clear;
      assign skid_valid      = 1'b0;
      assign skid_data       = '0;
      assign bus.in_ready    = !resetn && (!main_valid || bus.out_ready);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Without a skid slot, in_fire in ONE implies out_fire, so FULL is unreachable.
  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_load  = 1'b1;
            skid_clear = 1'b1;
            state_d    = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      EMPTY:   occ = OCC_EMPTY;
      ONE:     occ = OCC_ONE;
      FULL:    occ = OCC_TWO;
      default: occ = OCC_EMPTY;
    endcase
  end

  // A beat that out-fires during flush was delivered, so it is not a drop.
  assign stall_inc = {1'b0, main_valid && !bus.out_ready};
  assign drop_inc  = flush ? ({1'b0, main_valid && !bus.out_ready} + {1'b0, skid_valid})
                           : 2'd0;

  always_ff @(posedge clk) begin
    if (resetn) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      stall_cnt <= CNT_W'(sat_add(32'(stall_cnt), stall_inc, 32'(CNT_ONES)));
      drop_cnt  <= CNT_W'(sat_add(32'(drop_cnt), drop_inc, 32'(CNT_ONES)));
    end
  end

endmodule
